// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Fixed latency: start accepted at E0, results and done appear after E33 (for WIDTH=32).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic               sa_q, sb_q;
    logic [WIDTH-1:0]   a_orig_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_acc;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        abs_a = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

        // Multiply: multiplier sits in acc low half and shifts out LSB-first.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: dividend shifts out of acc low half MSB-first, quotient bits shift in.
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_acc   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];

        prod_fix = (op_q[0] && (sa_q ^ sb_q)) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = (op_q[0] && (sa_q ^ sb_q)) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = (op_q[0] && sa_q) ? (~rem_q + 1'b1) : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_orig_q <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q     <= op;
                        sa_q     <= a[WIDTH-1];
                        sb_q     <= b[WIDTH-1];
                        a_orig_q <= a;
                        opb_q    <= abs_b;
                        acc_q    <= {{WIDTH{1'b0}}, abs_a};
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (op_q[1]) begin
                        acc_q <= div_acc;
                        rem_q <= div_rem;
                    end else begin
                        acc_q <= mul_acc;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    if (!op_q[1]) begin
                        hi  <= prod_fix[2*WIDTH-1:WIDTH];
                        lo  <= prod_fix[WIDTH-1:0];
                        dbz <= 1'b0;
                    end else if (opb_q == '0) begin
                        hi  <= a_orig_q;
                        lo  <= '1;
                        dbz <= 1'b1;
                    end else begin
                        hi  <= rem_fix;
                        lo  <= quo_fix;
                        dbz <= 1'b0;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
